// File: rtl/pipe_muldiv_pkg.sv
// Shared types for the multi-cycle multiply/divide unit: operation codes,
// controller states and the divide-by-zero quotient pattern.
package pipe_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MSUB  = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } muldiv_state_t;

  // Wide enough for any supported operand width; users slice the low bits.
  localparam int MAX_W = 64;
  localparam logic [MAX_W-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/pipe_muldiv_div_step.sv
// One restoring-division iteration: shift remainder:quotient left by one,
// trial-subtract the divisor and keep the difference when it is non-negative.
module pipe_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    shifted = {rem_i, quot_i[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr_i};
    if (!trial[WIDTH]) begin
      rem_o  = trial[WIDTH-1:0];
      quot_o = {quot_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o  = shifted[WIDTH-1:0];
      quot_o = {quot_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/pipe_muldiv.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Define PIPE_MULDIV_MACC_EN to make MADD/MSUB accumulate into HI/LO.
module pipe_muldiv
  import pipe_muldiv_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int MUL_LAT = 2,
  localparam int CNT_W   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             waitrequest,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int PW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] DIV0_Q = DIV0_QUOT[WIDTH-1:0];

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return (~x) + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  muldiv_state_t    state_q, state_d;
  muldiv_op_t       op_in, op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d, dz_flag_q, dz_flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quot_q, quot_d, dvsr_q, dvsr_d, dvdnd_q, dvdnd_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d, bzero_q, bzero_d;
  logic [WIDTH-1:0] step_rem, step_quot;
  logic             accept;

  logic                    mul_signed, div_signed, a_neg, b_neg;
  logic signed [PW-1:0]    a_ext, b_ext;
  logic        [PW-1:0]    product;
  logic        [WIDTH-1:0] abs_a, abs_b;
  logic        [PW-1:0]    mul_chain_q [MUL_LAT];

  assign op_in  = muldiv_op_t'(op);
  assign accept = start && !waitrequest && (state_q == ST_IDLE);

  // Issue-side operand conditioning
  assign mul_signed = (op_in != OP_MULTU);
  assign a_ext      = mul_signed ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
  assign b_ext      = mul_signed ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
  assign product    = $unsigned(a_ext * b_ext);

  assign div_signed = (op_in == OP_DIV);
  assign a_neg      = div_signed && src_a[WIDTH-1];
  assign b_neg      = div_signed && src_b[WIDTH-1];
  assign abs_a      = a_neg ? neg_w(src_a) : src_a;
  assign abs_b      = b_neg ? neg_w(src_b) : src_b;

  pipe_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i  (rem_q),
    .quot_i (quot_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .quot_o (step_quot)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!waitrequest) begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            case (op_in)
              OP_MTHI, OP_MTLO: state_d = ST_IDLE;
              OP_DIV, OP_DIVU:  state_d = ST_DIV;
              default:          state_d = ST_MUL;
            endcase
          end
        end
        ST_MUL:  if (cnt_q == '0) state_d = ST_IDLE;
        ST_DIV:  if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
        ST_FIX:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  always_comb begin
    op_d      = op_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = done_q;
    dz_flag_d = dz_flag_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    dvsr_d    = dvsr_q;
    dvdnd_d   = dvdnd_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    bzero_d   = bzero_q;
    if (!waitrequest) begin
      done_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_d      = op_in;
            dz_flag_d = 1'b0;
            case (op_in)
              OP_MTHI: begin
                hi_d   = src_a;
                done_d = 1'b1;
              end
              OP_MTLO: begin
                lo_d   = src_a;
                done_d = 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                rem_d   = '0;
                quot_d  = abs_a;
                dvsr_d  = abs_b;
                dvdnd_d = src_a;
                qneg_d  = a_neg ^ b_neg;
                rneg_d  = a_neg;
                bzero_d = (src_b == '0);
                cnt_d   = CNT_W'(WIDTH);
              end
              default: cnt_d = CNT_W'(MUL_LAT - 1);
            endcase
          end
        end
        ST_MUL: begin
          if (cnt_q == '0) begin
            done_d = 1'b1;
`ifdef PIPE_MULDIV_MACC_EN
            case (op_q)
              OP_MADD: {hi_d, lo_d} = {hi_q, lo_q} + mul_chain_q[MUL_LAT-1];
              OP_MSUB: {hi_d, lo_d} = {hi_q, lo_q} - mul_chain_q[MUL_LAT-1];
              default: {hi_d, lo_d} = mul_chain_q[MUL_LAT-1];
            endcase
`else
            if (op_q == OP_MULT || op_q == OP_MULTU) begin
              {hi_d, lo_d} = mul_chain_q[MUL_LAT-1];
            end
`endif
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_DIV: begin
          rem_d  = step_rem;
          quot_d = step_quot;
          cnt_d  = cnt_q - CNT_W'(1);
        end
        ST_FIX: begin
          done_d = 1'b1;
          if (bzero_q) begin
            lo_d      = DIV0_Q;
            hi_d      = dvdnd_q;
            dz_flag_d = 1'b1;
          end else begin
            lo_d = qneg_q ? neg_w(quot_q) : quot_q;
            hi_d = rneg_q ? neg_w(rem_q) : rem_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Control and architectural state: reset clears HI/LO and aborts any operation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dz_flag_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dz_flag_q <= dz_flag_d;
      cnt_q     <= cnt_d;
    end
  end

  // Working datapath: only meaningful while the controller says so
  always_ff @(posedge clk) begin
    op_q    <= op_d;
    rem_q   <= rem_d;
    quot_q  <= quot_d;
    dvsr_q  <= dvsr_d;
    dvdnd_q <= dvdnd_d;
    qneg_q  <= qneg_d;
    rneg_q  <= rneg_d;
    bzero_q <= bzero_d;
    if (!waitrequest) begin
      if (accept) mul_chain_q[0] <= product;
      for (int i = 1; i < MUL_LAT; i++) mul_chain_q[i] <= mul_chain_q[i-1];
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign done     = done_q;
  assign div_zero = dz_flag_q;

endmodule
